dma_ldst_engine: RTL and testbench

- Single-channel load/store DMA engine sitting directly downstream of the core register file's DMA registers: start-address/word-count for load and for store.
- On a start pulse it walks memory word by word.
- Load: memory read data is streamed to the array over a valid/ready port.
- Store: words taken from the array's valid/ready port are written to memory.
- Reports busy and a one-cycle done pulse back to the core.

---
 rtl/dma_ldst_engine_pkg.sv | 21 ++
 rtl/dma_addr_cnt.sv | 36 +++
 rtl/dma_ldst_engine.sv | 122 ++++++++++++
 tb/tb_dma_ldst_engine.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ldst_engine_pkg.sv
// Shared widths, FSM state encodings and op encoding for the load/store DMA engine.
package dma_ldst_engine_pkg;

    localparam int DMA_CPU_W = 16;
    localparam int DMA_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_REQ = 3'd1,
        S_LD_OUT = 3'd2,
        S_ST_IN  = 3'd3,
        S_ST_REQ = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_t;

endpackage

// File: rtl/dma_addr_cnt.sv
// Word address / remaining-count pair for the DMA walk; o_last flags the final word.
module dma_addr_cnt #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    // Address increment wraps naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_cnt  <= i_cnt;
        end else if (i_step) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/dma_ldst_engine.sv
// Single-channel load/store DMA: walks memory one word at a time, streaming to/from the array.
import dma_ldst_engine_pkg::*;

module dma_ldst_engine #(
    parameter int CPU_W = DMA_CPU_W,
    parameter int CNT_W = DMA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start_ld,
    input  logic             i_start_st,
    input  logic [CPU_W-1:0] i_sa_ld,
    input  logic [CPU_W-1:0] i_dnum_ld,
    input  logic [CPU_W-1:0] i_sa_st,
    input  logic [CPU_W-1:0] i_dnum_st,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [CPU_W-1:0] o_mem_addr,
    output logic [CPU_W-1:0] o_mem_wdata,
    input  logic             i_mem_ack,
    input  logic [CPU_W-1:0] i_mem_rdata,
    output logic             o_ld_valid,
    output logic [CPU_W-1:0] o_ld_data,
    input  logic             i_ld_ready,
    input  logic             i_st_valid,
    input  logic [CPU_W-1:0] i_st_data,
    output logic             o_st_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_done_st
);

    state_t           r_state;
    state_t           w_next;
    op_t              r_op;
    logic [CPU_W-1:0] r_buf;

    logic             w_start;
    logic             w_sel_st;
    logic [CPU_W-1:0] w_start_addr;
    logic [CNT_W-1:0] w_start_cnt;
    logic             w_step;
    logic             w_last;
    logic [CPU_W-1:0] w_addr;

    // Load wins when both start pulses arrive together.
    assign w_start      = (r_state == S_IDLE) && (i_start_ld || i_start_st);
    assign w_sel_st     = !i_start_ld;
    assign w_start_addr = w_sel_st ? i_sa_st : i_sa_ld;
    assign w_start_cnt  = w_sel_st ? i_dnum_st[CNT_W-1:0] : i_dnum_ld[CNT_W-1:0];
    assign w_step       = ((r_state == S_LD_OUT) && i_ld_ready) ||
                          ((r_state == S_ST_REQ) && i_mem_ack);

    dma_addr_cnt #(
        .ADDR_W (CPU_W),
        .CNT_W  (CNT_W)
    ) u_addr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_start),
        .i_addr (w_start_addr),
        .i_cnt  (w_start_cnt),
        .i_step (w_step),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_start_cnt == '0) w_next = S_DONE;
                    else if (w_sel_st)     w_next = S_ST_IN;
                    else                   w_next = S_LD_REQ;
                end
            end
            S_LD_REQ: if (i_mem_ack)  w_next = S_LD_OUT;
            S_LD_OUT: if (i_ld_ready) w_next = w_last ? S_DONE : S_LD_REQ;
            S_ST_IN:  if (i_st_valid) w_next = S_ST_REQ;
            S_ST_REQ: if (i_mem_ack)  w_next = w_last ? S_DONE : S_ST_IN;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op  <= OP_LD;
            r_buf <= '0;
        end else begin
            if (w_start) r_op <= w_sel_st ? OP_ST : OP_LD;
            if ((r_state == S_LD_REQ) && i_mem_ack)
                r_buf <= i_mem_rdata;
            else if ((r_state == S_ST_IN) && i_st_valid)
                r_buf <= i_st_data;
        end
    end

    always_comb begin
        o_mem_req  = (r_state == S_LD_REQ) || (r_state == S_ST_REQ);
        o_mem_we   = (r_state == S_ST_REQ);
        o_ld_valid = (r_state == S_LD_OUT);
        o_st_ready = (r_state == S_ST_IN);
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_DONE);
        o_done_st  = (r_state == S_DONE) && (r_op == OP_ST);
    end

    assign o_mem_addr  = w_addr;
    assign o_mem_wdata = r_buf;
    assign o_ld_data   = r_buf;

endmodule

// File: tb/tb_dma_ldst_engine.sv
// Directed bench for dma_ldst_engine: memory/array responders plus expectation queues.
module tb_dma_ldst_engine;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start_ld, i_start_st;
    logic [15:0] i_sa_ld, i_dnum_ld, i_sa_st, i_dnum_st;
    logic        o_mem_req, o_mem_we;
    logic [15:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        o_ld_valid;
    logic [15:0] o_ld_data;
    logic        i_ld_ready;
    logic        i_st_valid;
    logic [15:0] i_st_data;
    logic        o_st_ready, o_busy, o_done, o_done_st;

    dma_ldst_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start_ld  (i_start_ld),
        .i_start_st  (i_start_st),
        .i_sa_ld     (i_sa_ld),
        .i_dnum_ld   (i_dnum_ld),
        .i_sa_st     (i_sa_st),
        .i_dnum_st   (i_dnum_st),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_ld_valid  (o_ld_valid),
        .o_ld_data   (o_ld_data),
        .i_ld_ready  (i_ld_ready),
        .i_st_valid  (i_st_valid),
        .i_st_data   (i_st_data),
        .o_st_ready  (o_st_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_done_st   (o_done_st)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mem_t        exp_mem[$];
    logic [15:0] exp_ld[$];
    logic        exp_done[$];
    logic [15:0] st_q[$];

    int ack_delay = 0, mem_wait = 0, n_mem = 0;
    int ld_hold = 0, ld_wait = 0, n_ld = 0;
    int done_cnt = 0, last_done_cyc = 0, last_ack_cyc = 0, first_req_cyc = -1;
    int start_cyc = 0;
    logic [15:0] s_addr, s_wdata, s_ld;
    logic        s_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs at each falling edge: inspects DUT outputs, then drives responses for the next rising edge.
    task automatic service();
        mem_t m;
        if (o_mem_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (mem_wait == 0) begin
                s_addr = o_mem_addr; s_we = o_mem_we; s_wdata = o_mem_wdata;
            end else begin
                chk("req_addr_stable", o_mem_addr, s_addr);
                chk("req_we_stable", o_mem_we, s_we);
                if (s_we) chk("req_wdata_stable", o_mem_wdata, s_wdata);
            end
            if (mem_wait >= ack_delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = o_mem_addr ^ 16'hA5A5;
                n_mem++;
                last_ack_cyc = cyc;
                mem_wait = 0;
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected_req", 1, 0);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_we", o_mem_we, m.we);
                    chk("mem_addr", o_mem_addr, m.addr);
                    if (m.we) chk("mem_wdata", o_mem_wdata, m.data);
                end
            end else begin
                i_mem_ack = 1'b0;
                mem_wait++;
            end
        end else begin
            i_mem_ack = 1'b0;
            mem_wait  = 0;
        end

        if (o_ld_valid) begin
            if (ld_wait == 0) s_ld = o_ld_data;
            else begin
                chk("ld_data_stable", o_ld_data, s_ld);
                chk("no_req_while_ld_held", o_mem_req, 0);
            end
            if (ld_wait >= ld_hold) begin
                i_ld_ready = 1'b1;
                ld_wait = 0;
                n_ld++;
                if (exp_ld.size() == 0) chk("ld_unexpected_word", 1, 0);
                else chk("ld_data", o_ld_data, exp_ld.pop_front());
            end else begin
                i_ld_ready = 1'b0;
                ld_wait++;
            end
        end else begin
            i_ld_ready = 1'b0;
            ld_wait    = 0;
        end

        if (o_st_ready && st_q.size() > 0) begin
            i_st_valid = 1'b1;
            i_st_data  = st_q.pop_front();
        end else begin
            i_st_valid = 1'b0;
        end

        if (o_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            chk("busy_in_done", o_busy, 1);
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_st", o_done_st, exp_done.pop_front());
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        i_start_ld = 1'b0;
        i_start_st = 1'b0;
        service();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        bit hit;
        d0  = done_cnt;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            cycle();
            if (done_cnt > d0) hit = 1;
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic push_ld(input logic [15:0] sa, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = sa + 16'(i);
            exp_mem.push_back('{we: 1'b0, addr: a, data: 16'h0});
            exp_ld.push_back(a ^ 16'hA5A5);
        end
    endtask

    task automatic start_ld(input logic [15:0] sa, input logic [15:0] n);
        cycle();
        i_start_ld = 1'b1; i_sa_ld = sa; i_dnum_ld = n;
        start_cyc = cyc; first_req_cyc = -1;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_mem_drained"}, exp_mem.size(), 0);
        chk({tag, "_ld_drained"}, exp_ld.size(), 0);
        chk({tag, "_done_drained"}, exp_done.size(), 0);
    endtask

    initial begin
        int n0, d0;
        rst_n = 1'b0;
        i_start_ld = 0; i_start_st = 0;
        i_sa_ld = 0; i_dnum_ld = 0; i_sa_st = 0; i_dnum_st = 0;
        i_mem_ack = 0; i_mem_rdata = 0; i_ld_ready = 0; i_st_valid = 0; i_st_data = 0;
        cycle(); cycle();
        chk("rst_req", o_mem_req, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ld_valid", o_ld_valid, 0);
        chk("rst_st_ready", o_st_ready, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        rst_n = 1'b1;
        cycle();

        // Load three words, zero-wait responders.
        push_ld(16'h0100, 3); exp_done.push_back(1'b0);
        start_ld(16'h0100, 16'd3);
        wait_done("ld3", 40);
        chk("ld3_first_req_lat", first_req_cyc - start_cyc, 1);
        chk("ld3_start_to_done", last_done_cyc - start_cyc, 7);
        chk("ld3_ack_to_done_le", (last_done_cyc - last_ack_cyc) >= 1, 1);
        cycle();
        chk("ld3_idle_busy", o_busy, 0);
        chk("ld3_idle_done", o_done, 0);
        drained("ld3");

        // Store two words with delayed ack.
        ack_delay = 3;
        st_q.push_back(16'h1111); st_q.push_back(16'h2222);
        exp_mem.push_back('{we: 1'b1, addr: 16'h0200, data: 16'h1111});
        exp_mem.push_back('{we: 1'b1, addr: 16'h0201, data: 16'h2222});
        exp_done.push_back(1'b1);
        cycle();
        i_start_st = 1'b1; i_sa_st = 16'h0200; i_dnum_st = 16'd2;
        wait_done("st2", 60);
        chk("st2_ack_to_done", last_done_cyc - last_ack_cyc, 1);
        chk("st2_data_used", st_q.size(), 0);
        drained("st2");
        ack_delay = 0;

        // Load with array backpressure.
        ld_hold = 5;
        push_ld(16'h0300, 2); exp_done.push_back(1'b0);
        start_ld(16'h0300, 16'd2);
        wait_done("ldbp", 60);
        drained("ldbp");
        ld_hold = 0;

        // Zero word count: done one cycle later, no memory traffic.
        n0 = n_mem;
        exp_done.push_back(1'b0);
        start_ld(16'h0123, 16'd0);
        wait_done("dnum0", 10);
        chk("dnum0_lat", last_done_cyc - start_cyc, 1);
        chk("dnum0_no_req", n_mem, n0);
        drained("dnum0");

        // Address wrap.
        push_ld(16'hFFFF, 2); exp_done.push_back(1'b0);
        start_ld(16'hFFFF, 16'd2);
        wait_done("wrap", 30);
        drained("wrap");

        // Simultaneous starts: load wins.
        push_ld(16'h0400, 1); exp_done.push_back(1'b0);
        cycle();
        i_start_ld = 1'b1; i_sa_ld = 16'h0400; i_dnum_ld = 16'd1;
        i_start_st = 1'b1; i_sa_st = 16'h0500; i_dnum_st = 16'd1;
        wait_done("both", 20);
        cycle(); cycle();
        chk("both_idle_after", o_busy, 0);
        drained("both");

        // Store start while busy is ignored.
        push_ld(16'h0410, 2); exp_done.push_back(1'b0);
        start_ld(16'h0410, 16'd2);
        cycle();
        i_start_st = 1'b1; i_sa_st = 16'h0600; i_dnum_st = 16'd1;
        wait_done("busy_st", 30);
        cycle(); cycle();
        chk("busy_st_idle_after", o_busy, 0);
        drained("busy_st");

        // Reset in the middle of a four-word load.
        push_ld(16'h0600, 1);
        n0 = n_ld;
        start_ld(16'h0600, 16'd4);
        for (int i = 0; i < 20 && n_ld == n0; i++) cycle();
        ack_delay = 100;
        cycle();
        chk("mid_in_ld_req", o_mem_req, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_req", o_mem_req, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_done, 0);
        rst_n = 1'b1;
        ack_delay = 0;
        cycle(); cycle();
        chk("mid_no_done", done_cnt, d0);
        drained("mid");

        push_ld(16'h0700, 2); exp_done.push_back(1'b0);
        start_ld(16'h0700, 16'd2);
        wait_done("post_rst", 30);
        chk("post_rst_first_req_lat", first_req_cyc - start_cyc, 1);
        drained("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
